// File: rtl/neighbor_table_writer.sv
// Neighbor table writer: takes one received beacon and updates the neighbor
// tables in shared node memory. It searches the neighborID table for the
// sender, overwrites that entry's fields on a hit, appends a new entry on a
// miss, and drops the beacon when the table is full.
module neighbor_table_writer #(
   parameter int          MAX_NEIGHBORS = 64,
   parameter logic [15:0] NID_BASE      = 16'h0048,
   parameter logic [15:0] CID_BASE      = 16'h00C8,
   parameter logic [15:0] BATT_BASE     = 16'h0148,
   parameter logic [15:0] QV_BASE       = 16'h01C8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] pkt_neighborID,
   input  logic [15:0] pkt_clusterID,
   input  logic [15:0] pkt_battery,
   input  logic [15:0] pkt_qvalue,
   input  logic [6:0]  neighbor_count,
   output logic [15:0] address,
   output logic        wr_en,
   output logic [15:0] mem_data_out,
   input  logic [15:0] mem_data_in,
   output logic [6:0]  new_neighbor_count,
   output logic        hit,
   output logic        dropped,
   output logic [5:0]  entry_index,
   output logic        done
);

   // A count at or above the capacity means the table is full; the search is
   // also bounded to the last legal index so an oversized count cannot run off.
   localparam logic [6:0] MAX_CNT  = 7'(MAX_NEIGHBORS);
   localparam logic [5:0] LAST_IDX = 6'(MAX_NEIGHBORS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_WAIT,
      S_CMP,
      S_APPEND_CHK,
      S_WR_NID,
      S_WR_CID,
      S_WR_BATT,
      S_WR_QV,
      S_FINISH
   } state_t;

   state_t      state_q, state_d;

   logic [5:0]  idx_q, idx_d;
   logic [15:0] id_q, id_d;
   logic [15:0] cid_q, cid_d;
   logic [15:0] batt_q, batt_d;
   logic [15:0] qv_q, qv_d;
   logic [6:0]  count_q, count_d;

   logic        hit_q, hit_d;
   logic        dropped_q, dropped_d;
   logic [5:0]  entry_index_q, entry_index_d;
   logic [6:0]  new_count_q, new_count_d;

   logic [15:0] address_q, address_d;
   logic        wr_en_q, wr_en_d;
   logic [15:0] data_q, data_d;
   logic        done_q, done_d;

   logic        last_entry;

   // One 16-bit word per entry, so the byte offset is the index times two.
   function automatic logic [15:0] word_off(input logic [5:0] ix);
      return {9'd0, ix, 1'b0};
   endfunction

   // The current compare is the final one when it reaches the latched count or the capacity.
   always_comb begin
      last_entry = ({1'b0, idx_q} == (count_q - 7'd1)) || (idx_q == LAST_IDX);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update: search, hit/miss decision, append/drop.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      id_d          = id_q;
      cid_d         = cid_q;
      batt_d        = batt_q;
      qv_d          = qv_q;
      count_d       = count_q;
      hit_d         = hit_q;
      dropped_d     = dropped_q;
      entry_index_d = entry_index_q;
      new_count_d   = new_count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               id_d      = pkt_neighborID;
               cid_d     = pkt_clusterID;
               batt_d    = pkt_battery;
               qv_d      = pkt_qvalue;
               count_d   = neighbor_count;
               hit_d     = 1'b0;
               dropped_d = 1'b0;
               idx_d     = 6'd0;
               state_d   = (neighbor_count == 7'd0) ? S_APPEND_CHK : S_RD_ADDR;
            end
         end
         S_RD_ADDR: state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = S_CMP;
         S_CMP: begin
            if (mem_data_in == id_q) begin
               hit_d         = 1'b1;
               entry_index_d = idx_q;
               state_d       = S_WR_CID;
            end else if (last_entry) begin
               state_d = S_APPEND_CHK;
            end else begin
               idx_d   = idx_q + 6'd1;
               state_d = S_RD_ADDR;
            end
         end
         S_APPEND_CHK: begin
            if (count_q >= MAX_CNT) begin
               dropped_d   = 1'b1;
               new_count_d = count_q;
               state_d     = S_FINISH;
            end else begin
               entry_index_d = count_q[5:0];
               state_d       = S_WR_NID;
            end
         end
         S_WR_NID:  state_d = S_WR_CID;
         S_WR_CID:  state_d = S_WR_BATT;
         S_WR_BATT: state_d = S_WR_QV;
         S_WR_QV:   state_d = S_FINISH;
         S_FINISH: begin
            new_count_d = (hit_q || dropped_q) ? count_q : (count_q + 7'd1);
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory port and done pulse, decoded from the state being entered so they are registered.
   always_comb begin
      address_d = address_q;
      wr_en_d   = 1'b0;
      data_d    = data_q;
      done_d    = 1'b0;
      case (state_d)
         S_RD_ADDR, S_RD_WAIT, S_CMP: begin
            address_d = NID_BASE + word_off(idx_d);
         end
         S_WR_NID: begin
            address_d = NID_BASE + word_off(entry_index_d);
            data_d    = id_q;
            wr_en_d   = 1'b1;
         end
         S_WR_CID: begin
            address_d = CID_BASE + word_off(entry_index_d);
            data_d    = cid_q;
            wr_en_d   = 1'b1;
         end
         S_WR_BATT: begin
            address_d = BATT_BASE + word_off(entry_index_d);
            data_d    = batt_q;
            wr_en_d   = 1'b1;
         end
         S_WR_QV: begin
            address_d = QV_BASE + word_off(entry_index_d);
            data_d    = qv_q;
            wr_en_d   = 1'b1;
         end
         S_FINISH: begin
            done_d = 1'b1;
         end
         default: begin
            wr_en_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; reset clears everything and aborts any update.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx_q         <= '0;
         id_q          <= '0;
         cid_q         <= '0;
         batt_q        <= '0;
         qv_q          <= '0;
         count_q       <= '0;
         hit_q         <= 1'b0;
         dropped_q     <= 1'b0;
         entry_index_q <= '0;
         new_count_q   <= '0;
         address_q     <= '0;
         wr_en_q       <= 1'b0;
         data_q        <= '0;
         done_q        <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         id_q          <= id_d;
         cid_q         <= cid_d;
         batt_q        <= batt_d;
         qv_q          <= qv_d;
         count_q       <= count_d;
         hit_q         <= hit_d;
         dropped_q     <= dropped_d;
         entry_index_q <= entry_index_d;
         new_count_q   <= new_count_d;
         address_q     <= address_d;
         wr_en_q       <= wr_en_d;
         data_q        <= data_d;
         done_q        <= done_d;
      end
   end

   assign address            = address_q;
   assign wr_en              = wr_en_q;
   assign mem_data_out       = data_q;
   assign new_neighbor_count = new_count_q;
   assign hit                = hit_q;
   assign dropped            = dropped_q;
   assign entry_index        = entry_index_q;
   assign done               = done_q;

endmodule

// File: tb/tb_neighbor_table_writer.sv
// Directed testbench for neighbor_table_writer with a small synchronous
// memory model and a write log used to check every memory write.
module tb_neighbor_table_writer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [15:0] pkt_neighborID;
   logic [15:0] pkt_clusterID;
   logic [15:0] pkt_battery;
   logic [15:0] pkt_qvalue;
   logic [6:0]  neighbor_count;
   logic [15:0] address;
   logic        wr_en;
   logic [15:0] mem_data_out;
   logic [15:0] mem_data_in;
   logic [6:0]  new_neighbor_count;
   logic        hit;
   logic        dropped;
   logic [5:0]  entry_index;
   logic        done;

   logic [15:0] mem [0:511];
   logic        pre_en;
   logic [15:0] pre_addr;
   logic [15:0] pre_data;
   logic [15:0] wr_addr_log [$];
   logic [15:0] wr_data_log [$];
   logic [15:0] exp_a [4];
   logic [15:0] exp_d [4];

   int checks;
   int failures;
   int lat;

   neighbor_table_writer dut (
      .clock              (clock),
      .reset              (reset),
      .start              (start),
      .pkt_neighborID     (pkt_neighborID),
      .pkt_clusterID      (pkt_clusterID),
      .pkt_battery        (pkt_battery),
      .pkt_qvalue         (pkt_qvalue),
      .neighbor_count     (neighbor_count),
      .address            (address),
      .wr_en              (wr_en),
      .mem_data_out       (mem_data_out),
      .mem_data_in        (mem_data_in),
      .new_neighbor_count (new_neighbor_count),
      .hit                (hit),
      .dropped            (dropped),
      .entry_index        (entry_index),
      .done               (done)
   );

   // 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Synchronous memory: one-cycle read latency, DUT writes are logged, bench preloads share the port.
   always @(posedge clock) begin
      if (pre_en) begin
         mem[pre_addr[9:1]] <= pre_data;
      end else if (wr_en) begin
         mem[address[9:1]] <= mem_data_out;
         wr_addr_log.push_back(address);
         wr_data_log.push_back(mem_data_out);
      end
      mem_data_in <= mem[address[9:1]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preloadId(input int idx, input logic [15:0] value);
      pre_en   = 1'b1;
      pre_addr = 16'h0048 + 16'(2 * idx);
      pre_data = value;
      @(negedge clock);
      pre_en   = 1'b0;
   endtask

   // Called on a negedge while the DUT is idle; returns on the negedge after done.
   task automatic applyStimulus(input logic [15:0] id, input logic [15:0] cid,
                                input logic [15:0] batt, input logic [15:0] q,
                                input logic [6:0] cnt, input bit poke, output int latency);
      bit got;
      wr_addr_log.delete();
      wr_data_log.delete();
      pkt_neighborID = id;
      pkt_clusterID  = cid;
      pkt_battery    = batt;
      pkt_qvalue     = q;
      neighbor_count = cnt;
      start          = 1'b1;
      got            = 1'b0;
      latency        = 0;
      for (int c = 1; c <= 400 && !got; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (poke && c == 2) begin
            start          = 1'b1;
            pkt_neighborID = 16'hBEEF;
            pkt_clusterID  = 16'h7777;
            pkt_qvalue     = 16'h5555;
            neighbor_count = 7'd0;
         end
         if (done) begin
            got     = 1'b1;
            latency = c;
         end
      end
      checkOutput("done_seen", 32'(got), 32'd1);
      @(negedge clock);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic checkWrites(input string tag, input int n);
      checkOutput({tag, "_nwrites"}, 32'(wr_addr_log.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < wr_addr_log.size()) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_log[i]), 32'(exp_a[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wr_data_log[i]), 32'(exp_d[i]));
         end
      end
   endtask

   task automatic checkResult(input string tag, input int latency, input int exp_lat,
                              input logic [6:0] exp_cnt, input logic exp_hit,
                              input logic exp_drop, input logic [5:0] exp_idx);
      checkOutput({tag, "_latency"}, 32'(latency), 32'(exp_lat));
      checkOutput({tag, "_new_count"}, 32'(new_neighbor_count), 32'(exp_cnt));
      checkOutput({tag, "_hit"}, 32'(hit), 32'(exp_hit));
      checkOutput({tag, "_dropped"}, 32'(dropped), 32'(exp_drop));
      if (!exp_drop) begin
         checkOutput({tag, "_index"}, 32'(entry_index), 32'(exp_idx));
      end
   endtask

   // Directed sequence of scenarios.
   initial begin
      bit found;
      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      start          = 1'b0;
      pre_en         = 1'b0;
      pre_addr       = '0;
      pre_data       = '0;
      pkt_neighborID = '0;
      pkt_clusterID  = '0;
      pkt_battery    = '0;
      pkt_qvalue     = '0;
      neighbor_count = '0;
      for (int i = 0; i < 512; i++) mem[i] = 16'hFFFF;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      checkOutput("rst_address", 32'(address), 32'd0);
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_data", 32'(mem_data_out), 32'd0);
      checkOutput("rst_new_count", 32'(new_neighbor_count), 32'd0);
      checkOutput("rst_hit", 32'(hit), 32'd0);
      checkOutput("rst_dropped", 32'(dropped), 32'd0);
      checkOutput("rst_index", 32'(entry_index), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);

      // Empty table: append at index 0.
      applyStimulus(16'd7, 16'd2, 16'd90, 16'd15, 7'd0, 1'b0, lat);
      exp_a = '{16'h0048, 16'h00C8, 16'h0148, 16'h01C8};
      exp_d = '{16'd7, 16'd2, 16'd90, 16'd15};
      checkWrites("empty", 4);
      checkResult("empty", lat, 6, 7'd1, 1'b0, 1'b0, 6'd0);

      // Hit at index 2 of {3,7,9}.
      preloadId(0, 16'd3);
      preloadId(1, 16'd7);
      preloadId(2, 16'd9);
      applyStimulus(16'd9, 16'd4, 16'd50, 16'd20, 7'd3, 1'b0, lat);
      exp_a = '{16'h00CC, 16'h014C, 16'h01CC, 16'h0000};
      exp_d = '{16'd4, 16'd50, 16'd20, 16'd0};
      checkWrites("hit", 3);
      checkResult("hit", lat, 13, 7'd3, 1'b1, 1'b0, 6'd2);

      // Append after {3,7}.
      applyStimulus(16'd5, 16'd1, 16'd60, 16'd11, 7'd2, 1'b0, lat);
      exp_a = '{16'h004C, 16'h00CC, 16'h014C, 16'h01CC};
      exp_d = '{16'd5, 16'd1, 16'd60, 16'd11};
      checkWrites("append", 4);
      checkResult("append", lat, 12, 7'd3, 1'b0, 1'b0, 6'd2);

      // Duplicate IDs {8,5,5}: lowest index wins.
      preloadId(0, 16'd8);
      preloadId(1, 16'd5);
      preloadId(2, 16'd5);
      applyStimulus(16'd5, 16'd3, 16'd33, 16'd44, 7'd3, 1'b0, lat);
      exp_a = '{16'h00CA, 16'h014A, 16'h01CA, 16'h0000};
      exp_d = '{16'd3, 16'd33, 16'd44, 16'd0};
      checkWrites("dup", 3);
      checkResult("dup", lat, 10, 7'd3, 1'b1, 1'b0, 6'd1);

      // Hit at index 0 with start pulsed (and inputs changed) while busy.
      preloadId(0, 16'd42);
      applyStimulus(16'd42, 16'd6, 16'd70, 16'd9, 7'd1, 1'b1, lat);
      exp_a = '{16'h00C8, 16'h0148, 16'h01C8, 16'h0000};
      exp_d = '{16'd6, 16'd70, 16'd9, 16'd0};
      checkWrites("busy", 3);
      checkResult("busy", lat, 7, 7'd1, 1'b1, 1'b0, 6'd0);

      // Full table, ID absent: dropped after 64 compares.
      for (int i = 0; i < 64; i++) preloadId(i, 16'h0100 + 16'(i));
      applyStimulus(16'd1, 16'd2, 16'd3, 16'd4, 7'd64, 1'b0, lat);
      checkWrites("full", 0);
      checkResult("full", lat, 194, 7'd64, 1'b0, 1'b1, 6'd0);

      // Oversized count treated as full, search still bounded to 64.
      applyStimulus(16'd1, 16'd2, 16'd3, 16'd4, 7'd70, 1'b0, lat);
      checkWrites("over", 0);
      checkResult("over", lat, 194, 7'd70, 1'b0, 1'b1, 6'd0);

      // Reset during WR_BATT aborts the update before WR_QV.
      wr_addr_log.delete();
      wr_data_log.delete();
      pkt_neighborID = 16'd21;
      pkt_clusterID  = 16'd22;
      pkt_battery    = 16'd23;
      pkt_qvalue     = 16'd24;
      neighbor_count = 7'd0;
      start          = 1'b1;
      found          = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (wr_en && address == 16'h0148) found = 1'b1;
      end
      checkOutput("rstmid_reach_batt", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rstmid_address", 32'(address), 32'd0);
      checkOutput("rstmid_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rstmid_data", 32'(mem_data_out), 32'd0);
      checkOutput("rstmid_new_count", 32'(new_neighbor_count), 32'd0);
      checkOutput("rstmid_hit", 32'(hit), 32'd0);
      checkOutput("rstmid_done", 32'(done), 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      exp_a = '{16'h0048, 16'h00C8, 16'h0148, 16'h0000};
      exp_d = '{16'd21, 16'd22, 16'd23, 16'd0};
      checkWrites("rstmid", 3);

      // Back-to-back starts after the abort: append then hit on the new entry.
      applyStimulus(16'd11, 16'd12, 16'd13, 16'd14, 7'd0, 1'b0, lat);
      exp_a = '{16'h0048, 16'h00C8, 16'h0148, 16'h01C8};
      exp_d = '{16'd11, 16'd12, 16'd13, 16'd14};
      checkWrites("post", 4);
      checkResult("post", lat, 6, 7'd1, 1'b0, 1'b0, 6'd0);
      applyStimulus(16'd11, 16'd31, 16'd32, 16'd33, 7'd1, 1'b0, lat);
      exp_a = '{16'h00C8, 16'h0148, 16'h01C8, 16'h0000};
      exp_d = '{16'd31, 16'd32, 16'd33, 16'd0};
      checkWrites("b2b", 3);
      checkResult("b2b", lat, 7, 7'd1, 1'b1, 1'b0, 6'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/neighbor_table_writer.md
Name: neighbor_table_writer

Overview:
- Write-side counterpart to the winner-policy reader. It takes one received beacon (neighbor ID, cluster ID, battery, Q-value) and updates the neighbor tables in shared node memory.
- Searches neighborID[0..count-1]. On a hit it overwrites that entry's cluster, battery and Q-value fields. On a miss it appends a new entry. When the table is full, a miss is dropped.
- Sits between the packet receive path and the shared mem block. Owns the memory port while busy.

Parameters:
- MAX_NEIGHBORS, 64, table capacity in entries.
- NID_BASE, 16'h0048, neighborID table base address.
- CID_BASE, 16'h00C8, clusterID table base address.
- BATT_BASE, 16'h0148, batteryStat table base address.
- QV_BASE, 16'h01C8, qValue table base address.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- pkt_neighborID  in  16  sender node ID.
- pkt_clusterID  in  16  sender cluster ID.
- pkt_battery  in  16  sender battery status.
- pkt_qvalue  in  16  sender advertised Q-value.
- neighbor_count  in  7  current valid entries (0..64); sampled at start.
- address  out  16  memory byte address; always even, one 16-bit word per entry.
- wr_en  out  1  memory write enable.
- mem_data_out  out  16  write data to memory.
- mem_data_in  in  16  read data; valid the cycle after address is presented.
- new_neighbor_count  out  7  count after update.
- hit  out  1  entry already existed.
- dropped  out  1  miss with table full; nothing written.
- entry_index  out  6  index written (hit or appended).
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high): state IDLE; address=0, wr_en=0, mem_data_out=0, new_neighbor_count=0, hit=0, dropped=0, entry_index=0, done=0.
- Reset asserted mid-operation aborts the update. Any write already issued stays in memory; no further writes are issued.
- start is ignored outside IDLE.
- IDLE, on start:
  - latch all pkt_* inputs and neighbor_count into internal registers;
  - clear hit and dropped;
  - i=0;
  - if count==0, go to APPEND_CHK; otherwise go to RD_ADDR.
- RD_ADDR: address=NID_BASE+2*i, wr_en=0. Next state RD_WAIT.
- RD_WAIT: one-cycle memory latency. Next state CMP.
- CMP:
  - mem_data_in==latched ID: hit=1, entry_index=i, go to WR_CID;
  - else if i==count-1: go to APPEND_CHK;
  - else: i=i+1, go to RD_ADDR.
- APPEND_CHK:
  - count>=MAX_NEIGHBORS: dropped=1, new_neighbor_count=count, go to FINISH;
  - else: entry_index=count, go to WR_NID.
- WR_NID: address=NID_BASE+2*idx, mem_data_out=ID, wr_en=1. Next state WR_CID.
- WR_CID: address=CID_BASE+2*idx, data=cluster, wr_en=1. Next state WR_BATT.
- WR_BATT: address=BATT_BASE+2*idx, data=battery, wr_en=1. Next state WR_QV.
- WR_QV: address=QV_BASE+2*idx, data=qvalue, wr_en=1. Next state FINISH.
- FINISH:
  - wr_en=0, done=1 for exactly one cycle;
  - new_neighbor_count = count+1 on append, otherwise count;
  - return to IDLE.
- wr_en is high only in the WR_* states, one cycle per word.
- Outputs hit, dropped, entry_index and new_neighbor_count hold their values until the next start.
- Address arithmetic is 16-bit unsigned; index is zero-extended, then shifted left by 1.
- Latency, start to done (cycles), for search depth k compares:
  - hit: 3k+4;
  - append: 3k+6;
  - drop: 3k+2;
  - empty table: 6.
- A neighbor_count above 64 is treated as full: search is bounded to 64 entries, then drop.
- Duplicate IDs in the table: the first (lowest index) match wins.

Test Plan:
- Empty table:
  - stimulus: count=0, start with ID=7, cid=2, batt=90, q=15;
  - required: writes 7@0x48, 2@0xC8, 90@0x148, 15@0x1C8; new_count=1, hit=0, index=0, done at cycle 6.
- Hit:
  - stimulus: table IDs {3,7,9}, count=3, start with ID=9, q=20;
  - required: no write to the neighborID table; writes land at 0xCC, 0x14C, 0x1CC (q=20); hit=1, index=2, new_count=3, latency 13.
- Append:
  - stimulus: IDs {3,7}, count=2, start with ID=5;
  - required: writes 5@0x4C and fields at index 2; new_count=3, hit=0, latency 12.
- Full:
  - stimulus: count=64, ID absent from the table;
  - required: dropped=1, zero wr_en pulses, new_count=64, done after 194 cycles.
- Reset mid-write:
  - stimulus: assert reset in WR_BATT;
  - required: WR_QV never occurs; all outputs return to 0 next cycle; a following start works normally.
- start pulsed while busy is ignored; back-to-back starts in IDLE each produce exactly one done pulse.
